// File: rtl/seq_8_bit_div.sv
// Restoring radix-2 divider: 2N-bit dividend / N-bit divisor. One quotient bit per cycle; result 2N cycles after accept (1 for divide-by-zero).
// Valid/ready on both sides; a stalled result holds its outputs and keeps in_ready low until it is taken.
module seq_8_bit_div #(
  parameter int N     = 8,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           dbz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [2*N-1:0]   r_q;
  logic [N-1:0]     r_d;
  logic [N-1:0]     r_r;
  logic [CNT_W-1:0] r_cnt;

  logic [N:0]       w_r_shift;
  logic [N:0]       w_t;
  logic             w_qbit;
  logic [N-1:0]     w_r_next;
  logic [2*N-1:0]   w_q_next;

  // The partial remainder stays below the divisor, so N bits hold it between
  // iterations; only the shifted value needs the extra bit.
  assign w_r_shift = {r_r, r_q[2*N-1]};
  assign w_t       = w_r_shift - {1'b0, r_d};
  assign w_qbit    = ~w_t[N];
  assign w_r_next  = w_qbit ? w_t[N-1:0] : w_r_shift[N-1:0];
  assign w_q_next  = {r_q[2*N-2:0], w_qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      r_cnt     <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_r       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (divisor != '0) begin
              r_q     <= dividend;
              r_d     <= divisor;
              r_r     <= '0;
              r_cnt   <= CNT_W'(2*N-1);
              dbz     <= 1'b0;
              r_state <= CALC;
            end else begin
              quotient  <= '1;
              remainder <= dividend[N-1:0];
              dbz       <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        CALC: begin
          r_q <= w_q_next;
          r_r <= w_r_next;
          if (r_cnt == '0) begin
            quotient  <= w_q_next;
            remainder <= w_r_next;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // Divide-by-zero arrives here with out_valid still low: raise it one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_8_bit_div.sv
// Randomised and directed bench for seq_8_bit_div against a plain-arithmetic reference.
module tb_seq_8_bit_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_8_bit_div #(.N(8), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r, output logic z);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = a / 16'(b);
      r = 8'(a % 16'(b));
      z = 1'b0;
    end
  endtask

  // Called at a negedge; returns at a negedge after the result handshake.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int hold, input bit pulse);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          lat;
    bit          bad;
    model(a, b, eq, er, ez);
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("in_ready_idle", in_ready, 1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    check("in_ready_busy", in_ready, 0);
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad = 1;
      if (pulse && lat == 5) begin
        in_valid = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, (b == 8'd0) ? 1 : 16);
    check("in_ready_calc", bad, 0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("dbz", dbz, ez);
    if (hold > 0) begin
      bad = 0;
      repeat (hold) begin
        @(posedge clk); @(negedge clk);
        if (!out_valid || in_ready || quotient !== eq || remainder !== er || dbz !== ez) bad = 1;
      end
      check("hold_stable", bad, 0);
      out_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int extra;
    logic [15:0] ra;
    logic [7:0]  rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", dbz, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'd1000, 8'd7, 0, 0);
    do_op(16'hFFFF, 8'hFF, 0, 0);
    do_op(16'hFE01, 8'd255, 0, 0);
    do_op(16'd0, 8'd5, 0, 0);
    do_op(16'h04D2, 8'd0, 0, 0);
    do_op(16'd9, 8'd3, 0, 0);
    do_op(16'd200, 8'd9, 10, 0);

    // A stray in_valid during CALC must not start a second operation.
    do_op(16'd100, 8'd3, 0, 1);
    extra = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) extra++;
    end
    check("single_result", extra, 0);

    // Abort mid-CALC with an asynchronous reset.
    dividend = 16'd1234;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) extra++;
    end
    check("abort_no_result", extra, 0);
    do_op(16'd60000, 8'd250, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0:       rb = 8'd0;
        1, 2:    rb = 8'($urandom_range(1, 15));
        default: rb = 8'($urandom);
      endcase
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      do_op(ra, rb, ($urandom_range(0, 15) == 0) ? 3 : 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
